// File: rtl/prime_sched.sv
// prime_sched: two-requester round-robin front end over an iterative trial-division primality engine.
// Optional build macro PRIME_ODD_SKIP_EN: after divisor 2, only odd divisors are tried.

module prime_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_num,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_num,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_num,
    output logic             rsp_prime,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH:0] D_ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] D_TWO = (WIDTH+1)'(2);

    // Divisor sequence: 2,3,4,... by default, or 2,3,5,7,... with odd skipping.
    function automatic logic [WIDTH:0] next_divisor(input logic [WIDTH:0] d);
`ifdef PRIME_ODD_SKIP_EN
        if (d == D_TWO) begin
            next_divisor = d + D_ONE;
        end else begin
            next_divisor = d + D_TWO;
        end
`else
        next_divisor = d + D_ONE;
`endif
    endfunction

    state_t             state_r;
    logic               last_grant_r;
    logic [WIDTH-1:0]   num_r;
    logic               id_r;
    logic [WIDTH:0]     d_r;
    logic               rsp_valid_r;
    logic               rsp_id_r;
    logic [WIDTH-1:0]   rsp_num_r;
    logic               rsp_prime_r;
    logic               busy_r;

    logic               idle_s;
    logic               r0_s;
    logic               r1_s;
    logic               accept_s;
    logic [WIDTH-1:0]   sel_num_s;
    logic               sel_id_s;
    logic               sel_small_s;
    logic [2*WIDTH+1:0] sq_s;
    logic [2*WIDTH+1:0] num_ext_s;
    logic [WIDTH:0]     rem_s;
    logic               d_over_s;
    logic               d_divides_s;

    // Round-robin arbitration: on a tie the requester not granted last time wins.
    always_comb begin
        idle_s   = (state_r == IDLE);
        r0_s     = idle_s & req0_valid & (~req1_valid | last_grant_r);
        r1_s     = idle_s & req1_valid & (~req0_valid | ~last_grant_r);
        accept_s = r0_s | r1_s;
        if (r1_s) begin
            sel_num_s = req1_num;
            sel_id_s  = 1'b1;
        end else begin
            sel_num_s = req0_num;
            sel_id_s  = 1'b0;
        end
        sel_small_s = (sel_num_s[WIDTH-1:1] == '0);
    end

    // Trial step: square is formed at full width so it can never wrap past num.
    always_comb begin
        sq_s        = {{(WIDTH+1){1'b0}}, d_r} * {{(WIDTH+1){1'b0}}, d_r};
        num_ext_s   = {{(WIDTH+2){1'b0}}, num_r};
        rem_s       = {1'b0, num_r} % d_r;
        d_over_s    = (sq_s > num_ext_s);
        d_divides_s = (rem_s == '0);
    end

    // Engine FSM; response fields are loaded on entry to DONE and held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            num_r        <= '0;
            id_r         <= 1'b0;
            d_r          <= D_TWO;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_num_r    <= '0;
            rsp_prime_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rsp_valid_r <= 1'b0;
                    if (accept_s) begin
                        num_r        <= sel_num_s;
                        id_r         <= sel_id_s;
                        last_grant_r <= sel_id_s;
                        d_r          <= D_TWO;
                        busy_r       <= 1'b1;
                        if (sel_small_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_id_r    <= sel_id_s;
                            rsp_num_r   <= sel_num_s;
                            rsp_prime_r <= 1'b0;
                            state_r     <= DONE;
                        end else begin
                            state_r <= CHECK;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                CHECK: begin
                    busy_r <= 1'b1;
                    if (d_over_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= id_r;
                        rsp_num_r   <= num_r;
                        rsp_prime_r <= 1'b1;
                        state_r     <= DONE;
                    end else if (d_divides_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= id_r;
                        rsp_num_r   <= num_r;
                        rsp_prime_r <= 1'b0;
                        state_r     <= DONE;
                    end else begin
                        d_r <= next_divisor(d_r);
                    end
                end
                DONE: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = r0_s;
    assign req1_ready = r1_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_num    = rsp_num_r;
    assign rsp_prime  = rsp_prime_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_prime_sched.sv
// Self-checking bench for prime_sched: timeline/arithmetic reference model plus directed vectors.
// Honours PRIME_ODD_SKIP_EN for the expected cycle counts.

module tb_prime_sched;

    localparam int W = 8;

`ifdef PRIME_ODD_SKIP_EN
    localparam int LAT253 = 7;
    localparam int LAT251 = 10;
`else
    localparam int LAT253 = 11;
    localparam int LAT251 = 16;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_num = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_num = '0;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_id;
    logic [W-1:0] rsp_num;
    logic         rsp_prime;
    logic         busy;

    prime_sched #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_num   (req0_num),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_num   (req1_num),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_num    (rsp_num),
        .rsp_prime  (rsp_prime),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Brute-force primality: independent of the square-root stopping rule.
    function automatic int is_prime_f(input int n);
        if (n < 2) return 0;
        for (int k = 2; k < n; k++) begin
            if (n % k == 0) return 0;
        end
        return 1;
    endfunction

    // Cycles from accept to response strobe.
    function automatic int lat_f(input int n);
        int d;
        int c;
        if (n < 2) return 1;
        d = 2;
        c = 0;
        forever begin
            c++;
            if (d * d > n || n % d == 0) return 1 + c;
`ifdef PRIME_ODD_SKIP_EN
            d = (d == 2) ? 3 : d + 2;
`else
            d = d + 1;
`endif
        end
    endfunction

    // Reference model state: cycles left until the engine is idle again.
    int m_left = 0;
    bit m_last = 1'b1;
    int m_id = 0;
    int m_num = 0;
    int m_prime = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_left = 0;
            m_last = 1'b1;
            chk("rst_busy", busy, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_num", rsp_num, 0);
            chk("rst_rsp_prime", rsp_prime, 0);
        end else begin
            bit idle;
            bit e0;
            bit e1;
            idle = (m_left == 0);
            chk("busy", busy, !idle);
            chk("rsp_valid", rsp_valid, (m_left == 1));
            if (m_left == 1) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_num", rsp_num, m_num);
                chk("rsp_prime", rsp_prime, m_prime);
            end
            e0 = idle && req0_valid && (!req1_valid || m_last);
            e1 = idle && req1_valid && (!req0_valid || !m_last);
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("two_readies", req0_ready & req1_ready, 0);
            if (e0 || e1) begin
                m_id    = e1;
                m_num   = e1 ? int'(req1_num) : int'(req0_num);
                m_prime = is_prime_f(m_num);
                m_last  = e1;
                m_left  = lat_f(m_num);
            end else if (m_left > 0) begin
                m_left--;
            end
        end
    end

    task automatic do_req(input bit id, input int n, input int exp_p, input int exp_lat);
        int acc;
        int lat;
        bit got;
        bit gotr;
        got  = 1'b0;
        gotr = 1'b0;
        acc  = 0;
        lat  = 0;
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1'b1;
            req1_num   = W'(n);
        end else begin
            req0_valid = 1'b1;
            req0_num   = W'(n);
        end
        for (int t = 0; t < 20; t++) begin
            #1;
            if ((id ? req1_ready : req0_ready) == 1'b1) begin
                got = 1'b1;
                acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!got) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        for (int t = 0; t < 40; t++) begin
            if (rsp_valid) begin
                gotr = 1'b1;
                lat  = cyc - acc;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rsp_seen", gotr, 1);
        if (gotr) begin
            chk("latency", lat, exp_lat);
            chk("dir_prime", rsp_prime, exp_p);
            chk("dir_num", rsp_num, n);
            chk("dir_id", rsp_id, id);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g[$];
        int rn[$];
        int rp[$];
        int cnt;

        chk("model_lat_7", lat_f(7), 3);
        chk("model_lat_253", lat_f(253), LAT253);
        chk("model_lat_251", lat_f(251), LAT251);
        chk("model_prime_251", is_prime_f(251), 1);
        chk("model_prime_253", is_prime_f(253), 0);

        // Both requesters valid from reset.
        req0_valid = 1'b1;
        req0_num   = 8'd10;
        req1_valid = 1'b1;
        req1_num   = 8'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (req0_ready) g.push_back(0);
            if (req1_ready) g.push_back(1);
            if (rsp_valid) begin
                rn.push_back(int'(rsp_num));
                rp.push_back(int'(rsp_prime));
            end
            @(posedge clk); #1;
        end
        chk("grant_count_ok", (g.size() >= 3) ? 1 : 0, 1);
        chk("rsp_count_ok", (rn.size() >= 2) ? 1 : 0, 1);
        if (g.size() >= 3) begin
            chk("grant0", g[0], 0);
            chk("grant1", g[1], 1);
            chk("grant2", g[2], 0);
        end
        if (rn.size() >= 2) begin
            chk("held_rsp0_num", rn[0], 10);
            chk("held_rsp0_prime", rp[0], 0);
            chk("held_rsp1_num", rn[1], 3);
            chk("held_rsp1_prime", rp[1], 1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int t = 0; t < 30 && busy; t++) begin
            @(posedge clk); #1;
        end
        chk("drain_idle", busy, 0);

        // Test-plan vectors with hand-computed latencies.
        do_req(1'b0, 7, 1, 3);
        do_req(1'b0, 253, 0, LAT253);
        do_req(1'b1, 251, 1, LAT251);
        do_req(1'b0, 0, 0, 1);
        do_req(1'b1, 1, 0, 1);
        do_req(1'b0, 2, 1, 2);
        do_req(1'b0, 4, 0, 2);

        // Reset in the middle of checking 251, with a stray valid pulse while busy.
        @(posedge clk); #1;
        req1_valid = 1'b1;
        req1_num   = 8'd251;
        #1;
        chk("rst_case_accept", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req0_num   = 8'd9;
        #1;
        chk("no_ready_while_busy", req0_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int t = 0; t < 25; t++) begin
            @(posedge clk); #1;
            if (rsp_valid) cnt++;
        end
        chk("no_rsp_after_rst", cnt, 0);
        do_req(1'b0, 4, 0, 2);

        // A few more operands, alternating requesters.
        do_req(1'b1, 97, 1, lat_f(97));
        do_req(1'b0, 121, 0, lat_f(121));
        do_req(1'b1, 169, 0, lat_f(169));
        do_req(1'b0, 255, 0, lat_f(255));
        do_req(1'b1, 211, 1, lat_f(211));
        do_req(1'b0, 128, 0, lat_f(128));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
